mag_timer: RTL and testbench

- Cook-time countdown timer for the microwave magnetron controller.
- Captures a 4-digit BCD time (MM:SS) from keypad digit strobes and counts it down once per second while the magnetron is enabled.
- Drives timer_done into the magnetron set/reset combinational stage, which feeds the magnetron SR latch. It also provides the digits to the display stage and a completion pulse to the beeper.

---
 rtl/mag_timer_if.sv | 32 +++
 rtl/mag_timer.sv | 101 ++++++++++
 tb/tb_mag_timer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mag_timer_if.sv
// mag_timer_if: groups the keypad/control inputs and the display/status
// outputs of the cook-time countdown timer.
//   clearn      : active-low synchronous clear of time and prescaler
//   enable      : magnetron on (count) / off (pause, entry allowed)
//   digit_valid : one-cycle keypad strobe
//   digit       : BCD key value (10-15 ignored)
//   min_tens, min_ones, sec_tens, sec_ones : displayed BCD time MM:SS
//   timer_done  : high whenever the time is 00:00
//   done_pulse  : one-cycle pulse when a decrement reaches 00:00
// The slave modport is the timer; the master modport is its controller.
interface mag_timer_if;
  logic       clearn;
  logic       enable;
  logic       digit_valid;
  logic [3:0] digit;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       timer_done;
  logic       done_pulse;

  modport slave (
    input  clearn, enable, digit_valid, digit,
    output min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse
  );

  modport master (
    output clearn, enable, digit_valid, digit,
    input  min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse
  );
endinterface

// File: rtl/mag_timer.sv
// mag_timer: microwave cook-time countdown timer.
// Captures a 4-digit BCD time MM:SS from keypad strobes (shifting in from
// the right) while paused, and counts it down one second per
// TICKS_PER_SEC clock cycles while enabled.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mag_timer_if.slave (controls in, display/status out)
module mag_timer #(
  parameter  int TICKS_PER_SEC = 1000,
  localparam int PS_W          = $clog2(TICKS_PER_SEC)
) (
  input  logic        clk,
  input  logic        reset,
  mag_timer_if.slave  bus
);

  // Digit index 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens.
  logic [3:0]      dig_q [4];
  logic [3:0]      dig_d [4];
  logic [3:0]      dec   [4];
  logic [PS_W-1:0] ps_q, ps_d;
  logic            done_q, done_d;
  logic            time_zero;
  logic            dec_zero;
  logic            tick;

  assign time_zero = (dig_q[0] == 4'd0) && (dig_q[1] == 4'd0) &&
                     (dig_q[2] == 4'd0) && (dig_q[3] == 4'd0);
  assign tick      = (ps_q == PS_W'(TICKS_PER_SEC - 1));

  // BCD borrow chain. Only used while the time is non-zero, so min_tens
  // never borrows from 0; its reload value is never observed.
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec[i] = dig_q[i];
      if (borrow) begin
        if (dig_q[i] == 4'd0) begin
          dec[i] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          dec[i] = dig_q[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  assign dec_zero = (dec[0] == 4'd0) && (dec[1] == 4'd0) &&
                    (dec[2] == 4'd0) && (dec[3] == 4'd0);

  always_comb begin
    dig_d  = dig_q;
    ps_d   = ps_q;
    done_d = 1'b0;
    if (!bus.clearn) begin
      for (int i = 0; i < 4; i++) dig_d[i] = 4'd0;
      ps_d = '0;
    end else if (bus.enable && !time_zero) begin
      if (tick) begin
        // Wrapping to 0 also covers clearing the prescaler at 00:00.
        ps_d   = '0;
        dig_d  = dec;
        done_d = dec_zero;
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end else if (!bus.enable && bus.digit_valid && (bus.digit <= 4'd9)) begin
      dig_d[0] = bus.digit;
      dig_d[1] = dig_q[0];
      dig_d[2] = dig_q[1];
      dig_d[3] = dig_q[2];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    always_ff @(posedge clk or posedge reset) begin
      if (reset) dig_q[gi] <= 4'd0;
      else       dig_q[gi] <= dig_d[gi];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q   <= '0;
      done_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      done_q <= done_d;
    end
  end

  assign bus.sec_ones   = dig_q[0];
  assign bus.sec_tens   = dig_q[1];
  assign bus.min_ones   = dig_q[2];
  assign bus.min_tens   = dig_q[3];
  assign bus.timer_done = time_zero;
  assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_mag_timer.sv
module tb_mag_timer;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: time held as a decimal number MMSS (0..9999).
  int m_val;
  int m_ps;
  int m_pulse;

  mag_timer_if tif ();
  mag_timer #(.TICKS_PER_SEC(T)) dut (.clk(clk), .reset(reset), .bus(tif.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_val();
    return tif.min_tens * 1000 + tif.min_ones * 100 + tif.sec_tens * 10 + tif.sec_ones;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".time"}, dut_val(), m_val);
    chk({tag, ".done"}, int'(tif.timer_done), (m_val == 0) ? 1 : 0);
    chk({tag, ".pulse"}, int'(tif.done_pulse), m_pulse);
  endtask

  task automatic model_step(input bit cl, input bit en, input bit dv, input int d);
    int mm, ss;
    m_pulse = 0;
    if (!cl) begin
      m_val = 0;
      m_ps  = 0;
    end else if (en && m_val != 0) begin
      if (m_ps == T - 1) begin
        m_ps = 0;
        mm = m_val / 100;
        ss = m_val % 100;
        if (ss > 0) ss--;
        else begin mm--; ss = 59; end
        m_val = mm * 100 + ss;
        if (m_val == 0) m_pulse = 1;
      end else begin
        m_ps++;
      end
    end else if (!en && dv && d <= 9) begin
      m_val = (m_val * 10 + d) % 10000;
    end
  endtask

  // One clock cycle with the given inputs; checks DUT against the model.
  task automatic cyc(input bit cl, input bit en, input bit dv, input int d, input string tag);
    tif.clearn      = cl;
    tif.enable      = en;
    tif.digit_valid = dv;
    tif.digit       = 4'(d);
    @(posedge clk);
    model_step(cl, en, dv, d);
    #1;
    chk_model(tag);
    $display("cyc %s cl=%0b en=%0b dv=%0b d=%0d -> %04d done=%0b pulse=%0b",
             tag, cl, en, dv, d, dut_val(), tif.timer_done, tif.done_pulse);
  endtask

  task automatic enter(input int d);
    cyc(1'b1, 1'b0, 1'b1, d, "entry");
  endtask

  task automatic run(input int n, input bit en, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b1, en, 1'b0, 0, tag);
  endtask

  initial begin
    tif.clearn = 1'b1; tif.enable = 1'b0; tif.digit_valid = 1'b0; tif.digit = 4'd0;
    reset = 1'b1;
    m_val = 0; m_ps = 0; m_pulse = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_model("post_reset");

    // 1. asynchronous reset mid-count
    enter(3); enter(7);
    run(2, 1'b1, "pre_rst");
    #3 reset = 1'b1;
    #1;
    m_val = 0; m_ps = 0; m_pulse = 0;
    chk("async_rst.time", dut_val(), 0);
    chk("async_rst.done", int'(tif.timer_done), 1);
    chk("async_rst.pulse", int'(tif.done_pulse), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 2. entry 1,0,5 then invalid digit 12
    cyc(1'b0, 1'b0, 1'b0, 0, "clr");
    enter(1); enter(0); enter(5);
    chk("entry_0105", dut_val(), 105);
    chk("entry_done0", int'(tif.timer_done), 0);
    enter(12);
    chk("entry_bad_digit", dut_val(), 105);

    // 3. 01:00 counting, strobe ignored while enabled
    cyc(1'b0, 1'b0, 1'b0, 0, "clr");
    enter(1); enter(0); enter(0);
    run(4, 1'b1, "cnt");
    chk("cnt_0059", dut_val(), 59);
    cyc(1'b1, 1'b1, 1'b1, 3, "cnt_strobe");
    run(3, 1'b1, "cnt");
    chk("cnt_0058", dut_val(), 58);

    // 4. pause/resume and completion
    cyc(1'b0, 1'b0, 1'b0, 0, "clr");
    enter(2);
    run(5, 1'b1, "run5");
    chk("pause_0001", dut_val(), 1);
    run(10, 1'b0, "pause");
    chk("paused_0001", dut_val(), 1);
    run(2, 1'b1, "resume");
    chk("resume_not_yet", dut_val(), 1);
    run(1, 1'b1, "resume");
    chk("final_0000", dut_val(), 0);
    chk("final_pulse", int'(tif.done_pulse), 1);
    chk("final_done", int'(tif.timer_done), 1);
    run(1, 1'b1, "hold");
    chk("pulse_one_cycle", int'(tif.done_pulse), 0);
    run(6, 1'b1, "hold");
    chk("hold_0000", dut_val(), 0);

    // 5. full borrow chain and sec_tens above 5
    cyc(1'b0, 1'b0, 1'b0, 0, "clr");
    enter(1); enter(0); enter(0); enter(0);
    run(4, 1'b1, "borrow");
    chk("borrow_0959", dut_val(), 959);
    cyc(1'b0, 1'b0, 1'b0, 0, "clr");
    enter(9); enter(0);
    run(4, 1'b1, "st9");
    chk("st9_0089", dut_val(), 89);

    // 6. clearn while counting
    cyc(1'b0, 1'b0, 1'b0, 0, "clr");
    enter(5); enter(3); enter(0);
    run(2, 1'b1, "c530");
    cyc(1'b0, 1'b1, 1'b0, 0, "clr_en");
    chk("clr_time", dut_val(), 0);
    chk("clr_pulse", int'(tif.done_pulse), 0);
    run(1, 1'b1, "idle_en");
    enter(4);
    run(3, 1'b1, "ps_zero");
    chk("ps_cleared_0004", dut_val(), 4);
    run(1, 1'b1, "ps_zero");
    chk("ps_cleared_0003", dut_val(), 3);

    // Randomized phase against the model
    begin
      bit en_r = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 9) == 0) en_r = ~en_r;
        cyc(($urandom_range(0, 40) != 0), en_r, ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 15)), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
